tick_countdown_timer: RTL and testbench
=======================================

// Module: tick_countdown_timer
// PURPOSE
//  Parametrised game countdown timer. Divides an incoming sub-second strobe (tick_in, e.g. 100 ms)
//  into whole-second pulses and counts a loaded number of seconds down to zero. Provides
//  start/pause/clear control, optional auto-reload, and a remaining-seconds value for the
//  display path. Sits between the base tick generator and the game-control FSM.
// PARAMETERS
//  TICKS_PER_SEC  10   tick_in strobes per second; must be >= 2
//  SEC_W          7    width of load_val/remaining; 120 s needs 7
//  AUTO_RELOAD    0    1: on expiry reload load_val and keep running; 0: stop in EXPIRED
// PORTS
//  clk        in   1      single clock; all logic rising-edge
//  rst        in   1      asynchronous, active-high reset
//  tick_in    in   1      one-cycle strobe from the base tick generator
//  start      in   1      one-cycle: load load_val, zero prescaler, enter RUN
//  pause      in   1      level: while 1, counting is frozen
//  clear      in   1      one-cycle: return to IDLE, remaining <= 0
//  load_val   in   SEC_W  seconds to count; sampled only on start (and on auto-reload)
//  remaining  out  SEC_W  seconds left
//  sec_pulse  out  1      one-cycle pulse per elapsed second while counting
//  running    out  1      1 in RUN or PAUSED
//  expired    out  1      level, 1 in EXPIRED
//  done_pulse out  1      one-cycle pulse on each reach of zero
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, remaining=0, sec_pulse=0, done_pulse=0; running/expired decode 0.
//  States: IDLE, RUN, PAUSED, EXPIRED. Control priority per cycle: clear > start > pause.
//  - clear (any state): -> IDLE, remaining=0, prescaler=0; no pulses that cycle.
//  - start (any state, no clear): remaining<=load_val, prescaler<=0, -> RUN; restart if already RUN.
//    load_val==0: -> EXPIRED directly, done_pulse=1 next cycle (AUTO_RELOAD ignored for zero load).
//  - RUN & pause=1 -> PAUSED; PAUSED & pause=0 -> RUN. Prescaler and remaining hold in PAUSED;
//    tick_in is ignored in PAUSED, IDLE, EXPIRED.
//  Prescaler (RUN only): on tick_in, if prescaler==TICKS_PER_SEC-1 then prescaler<=0 (terminal
//    tick) else prescaler+1. Exactly one terminal tick per TICKS_PER_SEC accepted ticks; no
//    extra clock-driven wrap. Width $clog2(TICKS_PER_SEC).
//  Terminal tick in RUN: sec_pulse=1 on the following cycle (registered, 1-cycle latency);
//    remaining<=remaining-1 in same update.
//    If remaining==1: AUTO_RELOAD=0 -> EXPIRED, remaining=0; AUTO_RELOAD=1 -> remaining<=load_val,
//    stay RUN (load_val==0 here -> EXPIRED). done_pulse=1 aligned with that sec_pulse.
//  remaining never wraps below 0. Pulses never extend beyond one cycle, even with back-to-back ticks.
//  EXPIRED holds remaining=0 until start or clear.
//  Same-cycle tick_in with pause rising: tick discarded (pause wins). Tick with start: discarded.
//  Async rst mid-count: immediate return to reset values; no pulse on release.
// STRUCTURE
//  Shared package timer_pkg: state encoding (IDLE=0,RUN=1,PAUSED=2,EXPIRED=3), TIMER_SEC_W default.
//  Sub-module tick_prescaler (TICKS_PER_SEC): inputs clk, rst, clr, en, tick_in; output term
//    (combinational terminal-tick flag). Top holds FSM, remaining counter, output registers.
// TESTING (TICKS_PER_SEC=10, SEC_W=7)
//  1 load_val=120, start, 1200 ticks -> 120 sec_pulse, remaining 120..0, one done_pulse, expired=1.
//  2 load_val=3, start, pause high for 25 ticks after 15 ticks, resume -> done after 30 accepted
//    ticks total; remaining holds 2 during pause; no sec_pulse while paused.
//  3 AUTO_RELOAD=1, load_val=2, 60 ticks -> 3 done_pulse, 6 sec_pulse, running stays 1.
//  4 start with load_val=0 -> EXPIRED next cycle, done_pulse single cycle, remaining=0.
//  5 clear and start same cycle at remaining=50 -> IDLE, remaining=0; start at 9th tick -> prescaler
//    restart, first sec_pulse after 10 more ticks.
//  6 assert rst asynchronously mid-RUN (between clk edges) -> outputs 0 immediately; back-to-back
//    tick_in every cycle -> sec_pulse every 10th cycle, always width 1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the game countdown timer: state encoding and default widths.
package timer_pkg;

  localparam int unsigned TIMER_SEC_W         = 7;
  localparam int unsigned TIMER_TICKS_PER_SEC = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides accepted tick_in strobes by TICKS_PER_SEC; term flags the terminal tick combinationally.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TIMER_TICKS_PER_SEC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick_in,
  output logic term
);

  localparam int unsigned CNT_W = cnt_width(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign term = en && tick_in && (cnt_q == LAST);

  // Counter only advances on accepted ticks; clr has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick_in) begin
      cnt_d = term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_countdown_timer.sv
// Game countdown timer: seconds derived from tick_in, counted down from load_val with
// start/pause/clear control and optional auto-reload.
module tick_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TIMER_TICKS_PER_SEC,
  parameter int unsigned SEC_W         = TIMER_SEC_W,
  parameter int unsigned AUTO_RELOAD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [SEC_W-1:0] load_val,
  output logic [SEC_W-1:0] remaining,
  output logic             sec_pulse,
  output logic             running,
  output logic             expired,
  output logic             done_pulse
);

  timer_state_e     state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic             sec_q, sec_d;
  logic             done_q, done_d;
  logic             pre_en, pre_clr, term;

  // Ticks are accepted only while genuinely running; pause, start and clear all swallow them.
  assign pre_en  = (state_q == ST_RUN) && !pause && !start && !clear;
  assign pre_clr = start || clear;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (pre_clr),
    .en     (pre_en),
    .tick_in(tick_in),
    .term   (term)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sec_d   = 1'b0;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (start) begin
      if (load_val == '0) begin
        state_d = ST_EXPIRED;
        rem_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        rem_d   = load_val;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (term) begin
            sec_d = 1'b1;
            // Last second: either reload (nonzero load only) or park in EXPIRED.
            if (rem_q <= SEC_W'(1)) begin
              done_d = 1'b1;
              if ((AUTO_RELOAD != 0) && (load_val != '0)) begin
                rem_d = load_val;
              end else begin
                state_d = ST_EXPIRED;
                rem_d   = '0;
              end
            end else begin
              rem_d = rem_q - SEC_W'(1);
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  assign remaining  = rem_q;
  assign sec_pulse  = sec_q;
  assign done_pulse = done_q;
  assign running    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign expired    = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Scoreboard bench for tick_countdown_timer: one-shot instance and an auto-reload instance.
module tb_tick_countdown_timer;

  typedef struct packed {
    logic [6:0] rem;
    logic       sec;
    logic       done;
    logic       run;
    logic       exp;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick1 = 1'b0, start1 = 1'b0, pause1 = 1'b0, clear1 = 1'b0;
  logic [6:0] load1 = '0;
  logic [6:0] rem1;
  logic       sec1, run1, exp1, done1;
  logic       tick2 = 1'b0, start2 = 1'b0, pause2 = 1'b0, clear2 = 1'b0;
  logic [6:0] load2 = '0;
  logic [6:0] rem2;
  logic       sec2, run2, exp2, done2;

  int vectors = 0;
  int miscompares = 0;
  ev_t q1[$];
  ev_t q2[$];
  ev_t act1, act2, exp_ev;

  always #5 clk = ~clk;

  tick_countdown_timer #(.TICKS_PER_SEC(10), .SEC_W(7), .AUTO_RELOAD(0)) dut1 (
    .clk(clk), .rst(rst), .tick_in(tick1), .start(start1), .pause(pause1), .clear(clear1),
    .load_val(load1), .remaining(rem1), .sec_pulse(sec1), .running(run1), .expired(exp1),
    .done_pulse(done1)
  );

  tick_countdown_timer #(.TICKS_PER_SEC(10), .SEC_W(7), .AUTO_RELOAD(1)) dut2 (
    .clk(clk), .rst(rst), .tick_in(tick2), .start(start2), .pause(pause2), .clear(clear2),
    .load_val(load2), .remaining(rem2), .sec_pulse(sec2), .running(run2), .expired(exp2),
    .done_pulse(done2)
  );

  function automatic ev_t mk(input int rem, input bit s, input bit d, input bit r, input bit e);
    ev_t v;
    v.rem  = 7'(rem);
    v.sec  = s;
    v.done = d;
    v.run  = r;
    v.exp  = e;
    return v;
  endfunction

  // Monitor: every pulse from either DUT must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      act1 = {rem1, sec1, done1, run1, exp1};
      act2 = {rem2, sec2, done2, run2, exp2};
      if (sec1 || done1) begin
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL dut1_unexpected_pulse t=%0t got rem=%0d sec=%b done=%b run=%b exp=%b",
                   $time, act1.rem, act1.sec, act1.done, act1.run, act1.exp);
        end else begin
          exp_ev = q1.pop_front();
          if (act1 !== exp_ev) begin
            miscompares++;
            $display("FAIL dut1_pulse t=%0t got rem=%0d sec=%b done=%b run=%b exp=%b want rem=%0d sec=%b done=%b run=%b exp=%b",
                     $time, act1.rem, act1.sec, act1.done, act1.run, act1.exp,
                     exp_ev.rem, exp_ev.sec, exp_ev.done, exp_ev.run, exp_ev.exp);
          end
        end
      end
      if (sec2 || done2) begin
        vectors++;
        if (q2.size() == 0) begin
          miscompares++;
          $display("FAIL dut2_unexpected_pulse t=%0t got rem=%0d sec=%b done=%b run=%b exp=%b",
                   $time, act2.rem, act2.sec, act2.done, act2.run, act2.exp);
        end else begin
          exp_ev = q2.pop_front();
          if (act2 !== exp_ev) begin
            miscompares++;
            $display("FAIL dut2_pulse t=%0t got rem=%0d sec=%b done=%b run=%b exp=%b want rem=%0d sec=%b done=%b run=%b exp=%b",
                     $time, act2.rem, act2.sec, act2.done, act2.run, act2.exp,
                     exp_ev.rem, exp_ev.sec, exp_ev.done, exp_ev.run, exp_ev.exp);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic tick(input int which, input int gap);
    if (which == 1) tick1 = 1'b1;
    else            tick2 = 1'b1;
    cyc();
    tick1 = 1'b0;
    tick2 = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic start_dut(input int which, input int val);
    if (which == 1) begin
      load1 = 7'(val);
      start1 = 1'b1;
    end else begin
      load2 = 7'(val);
      start2 = 1'b1;
    end
    cyc();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("reset_outputs1", int'({rem1, sec1, done1, run1, exp1}), 0);
    chk("reset_outputs2", int'({rem2, sec2, done2, run2, exp2}), 0);
    rst = 1'b0;
    cyc();

    // 1: 120 s countdown, one tick every other cycle
    start_dut(1, 120);
    chk("t1_loaded", int'(rem1), 120);
    for (int i = 1; i <= 1200; i++) begin
      if (i % 10 == 0) q1.push_back(mk(120 - i / 10, 1'b1, i == 1200, i != 1200, i == 1200));
      tick(1, 1);
    end
    chk("t1_expired", int'({run1, exp1}), 1);

    // 2: pause for 25 ticks after 15 accepted ticks
    start_dut(1, 3);
    for (int i = 1; i <= 15; i++) begin
      if (i == 10) q1.push_back(mk(2, 1'b1, 1'b0, 1'b1, 1'b0));
      tick(1, 0);
    end
    pause1 = 1'b1;
    cyc();
    for (int i = 0; i < 25; i++) tick(1, 0);
    chk("t2_paused_rem", int'(rem1), 2);
    chk("t2_paused_running", int'(run1), 1);
    pause1 = 1'b0;
    cyc();
    for (int i = 16; i <= 30; i++) begin
      if (i == 20) q1.push_back(mk(1, 1'b1, 1'b0, 1'b1, 1'b0));
      if (i == 30) q1.push_back(mk(0, 1'b1, 1'b1, 1'b0, 1'b1));
      tick(1, 0);
    end

    // 3: auto-reload of 2 s over 60 ticks
    start_dut(2, 2);
    for (int i = 1; i <= 60; i++) begin
      if (i % 10 == 0) begin
        if (((i / 10) % 2) == 1) q2.push_back(mk(1, 1'b1, 1'b0, 1'b1, 1'b0));
        else                     q2.push_back(mk(2, 1'b1, 1'b1, 1'b1, 1'b0));
      end
      tick(2, 0);
    end
    chk("t3_running", int'({run2, exp2}), 2);

    // 4: zero load expires immediately with a single done pulse
    load1 = 7'd0;
    start1 = 1'b1;
    q1.push_back(mk(0, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc();
    start1 = 1'b0;
    repeat (2) cyc();
    chk("t4_state", int'({rem1, run1, exp1}), 1);

    // 5: clear beats start, then start coinciding with a would-be terminal tick
    start_dut(1, 60);
    for (int i = 1; i <= 100; i++) begin
      if (i % 10 == 0) q1.push_back(mk(60 - i / 10, 1'b1, 1'b0, 1'b1, 1'b0));
      tick(1, 0);
    end
    chk("t5_rem50", int'(rem1), 50);
    clear1 = 1'b1;
    start1 = 1'b1;
    cyc();
    clear1 = 1'b0;
    start1 = 1'b0;
    cyc();
    chk("t5_cleared", int'({rem1, run1, exp1}), 0);
    start_dut(1, 5);
    for (int i = 0; i < 9; i++) tick(1, 0);
    start1 = 1'b1;
    tick(1, 0);
    start1 = 1'b0;
    for (int i = 0; i < 9; i++) tick(1, 0);
    chk("t5_no_early_pulse", int'(rem1), 5);
    q1.push_back(mk(4, 1'b1, 1'b0, 1'b1, 1'b0));
    tick(1, 0);

    // 6: asynchronous reset mid-run, then back-to-back ticks
    start_dut(1, 7);
    for (int i = 1; i <= 15; i++) begin
      if (i == 10) q1.push_back(mk(6, 1'b1, 1'b0, 1'b1, 1'b0));
      tick(1, 0);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_reset", int'({rem1, sec1, done1, run1, exp1}), 0);
    cyc();
    #2 rst = 1'b0;
    repeat (3) cyc();
    chk("t6_after_release", int'({rem1, run1, exp1}), 0);
    start_dut(1, 3);
    tick1 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      if (c % 10 == 0) q1.push_back(mk(3 - c / 10, 1'b1, c == 30, c != 30, c == 30));
      cyc();
    end
    tick1 = 1'b0;
    repeat (5) cyc();

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
